// File: rtl/mcu_sequencer_if.sv
// Program-load handshake between the host/boot interface and the sequencer.
interface mcu_sequencer_if;
   logic        load_valid;
   logic [11:0] load_data;
   logic        load_last;
   logic        load_ready;

   modport master (
      output load_valid,
      output load_data,
      output load_last,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_last,
      output load_ready
   );
endinterface

// File: rtl/mcu_sequencer.sv
// Top-level sequencer for the 12-bit MCU core: program loading followed by
// FETCH/DECODE/EXECUTE sequencing under run, step and halt control.
module mcu_sequencer #(
   parameter int unsigned PROG_DEPTH = 256,
   parameter int unsigned ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   mcu_sequencer_if.slave    load,
   input  logic              run_en,
   input  logic              step_req,
   input  logic              halt_req,
   input  logic              reload_req,
   output logic [1:0]        State,
   output logic [ADDR_W-1:0] ProgLoad_Addr,
   output logic [11:0]       ProgLoad_Data,
   output logic              core_rst,
   output logic              load_done,
   output logic              running,
   output logic [15:0]       retired_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READY,
      S_FETCH,
      S_DECODE,
      S_EXEC
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   load_addr;
   logic                step_flag;
   logic                halt_seen;
   logic                step_q;

   logic                accept;
   logic                load_complete;
   logic                step_rise;
   logic                exec_stop;

   // A held step_req only counts on its rising edge, so one step per press.
   assign step_rise     = step_req & ~step_q;
   assign accept        = (state == S_IDLE) & load.load_valid;
   assign load_complete = load.load_last | (load_addr == ADDR_W'(PROG_DEPTH - 1));
   // halt_req in the EXEC cycle itself must also stop after this instruction.
   assign exec_stop     = step_flag | halt_seen | halt_req | ~run_en;

   assign ProgLoad_Addr = load_addr;
   assign ProgLoad_Data = load.load_data;
   assign running       = (state == S_FETCH) | (state == S_DECODE) | (state == S_EXEC);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state decode plus State bus and load_ready generation.
   always_comb begin
      state_next      = state;
      State           = 2'b01;
      load.load_ready = 1'b0;
      case (state)
         S_IDLE: begin
            load.load_ready = 1'b1;
            // FETCH doubles as the idle encoding; LOAD only while a word is offered.
            if (load.load_valid) State = 2'b00;
            if (accept && load_complete) state_next = S_READY;
         end
         S_READY: begin
            if (reload_req)     state_next = S_IDLE;
            else if (run_en)    state_next = S_FETCH;
            else if (step_rise) state_next = S_FETCH;
         end
         S_FETCH: begin
            State      = 2'b01;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            State      = 2'b10;
            state_next = S_EXEC;
         end
         S_EXEC: begin
            State      = 2'b11;
            state_next = exec_stop ? S_READY : S_FETCH;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Load address, status flags, step/halt bookkeeping and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_addr   <= '0;
         load_done   <= 1'b0;
         core_rst    <= 1'b0;
         step_flag   <= 1'b0;
         halt_seen   <= 1'b0;
         step_q      <= 1'b0;
         retired_cnt <= '0;
      end else begin
         step_q   <= step_req;
         core_rst <= accept & load_complete;
         if (accept) begin
            load_addr <= load_addr + ADDR_W'(1);
            if (load_complete) load_done <= 1'b1;
         end
         if (state == S_READY) begin
            if (reload_req) begin
               load_addr <= '0;
               load_done <= 1'b0;
            end else if (!run_en && step_rise) begin
               step_flag <= 1'b1;
            end
         end
         if (running && halt_req) halt_seen <= 1'b1;
         if (state == S_EXEC) begin
            retired_cnt <= retired_cnt + 16'd1;
            if (exec_stop) begin
               step_flag <= 1'b0;
               halt_seen <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Scoreboard bench for mcu_sequencer: directed stimulus pushes expected
// program writes and retire counts; a negedge monitor pops and compares.
module tb_mcu_sequencer;
   logic        clk;
   logic        rst;
   logic        run_en;
   logic        step_req;
   logic        halt_req;
   logic        reload_req;
   logic [1:0]  State;
   logic [7:0]  ProgLoad_Addr;
   logic [11:0] ProgLoad_Data;
   logic        core_rst;
   logic        load_done;
   logic        running;
   logic [15:0] retired_cnt;

   mcu_sequencer_if bus ();

   mcu_sequencer #(.PROG_DEPTH(256), .ADDR_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .load          (bus.slave),
      .run_en        (run_en),
      .step_req      (step_req),
      .halt_req      (halt_req),
      .reload_req    (reload_req),
      .State         (State),
      .ProgLoad_Addr (ProgLoad_Addr),
      .ProgLoad_Data (ProgLoad_Data),
      .core_rst      (core_rst),
      .load_done     (load_done),
      .running       (running),
      .retired_cnt   (retired_cnt)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [11:0] data;
   } ld_t;

   ld_t         ld_q[$];
   logic [15:0] ex_q[$];
   int          checks = 0;
   int          errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [11:0] d, input logic last, input logic [7:0] a);
      ld_t e;
      e.addr = a;
      e.data = d;
      ld_q.push_back(e);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      bus.load_last  = last;
      cyc();
   endtask

   // Monitor: every LOAD cycle is a program write, every EXECUTE cycle retires.
   always @(negedge clk) begin
      if (!rst) begin
         if (State == 2'b00) begin
            if (ld_q.size() == 0) begin
               chk("unexpected_load_write", 32'(ProgLoad_Addr), 32'hFFFF_FFFF);
            end else begin
               ld_t e;
               e = ld_q.pop_front();
               chk("load_addr", 32'(ProgLoad_Addr), 32'(e.addr));
               chk("load_data", 32'(ProgLoad_Data), 32'(e.data));
            end
         end
         if (State == 2'b11) begin
            if (ex_q.size() == 0) begin
               chk("unexpected_exec", 32'(retired_cnt), 32'hFFFF_FFFF);
            end else begin
               logic [15:0] x;
               x = ex_q.pop_front();
               chk("exec_retired", 32'(retired_cnt), 32'(x));
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [1:0] seq [3];

   initial begin
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11;
      rst = 1'b1; run_en = 1'b0; step_req = 1'b0; halt_req = 1'b0; reload_req = 1'b0;
      bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Reset values
      chk("rst_State", 32'(State), 32'h1);
      chk("rst_load_ready", 32'(bus.load_ready), 32'h1);
      chk("rst_load_done", 32'(load_done), 32'h0);
      chk("rst_core_rst", 32'(core_rst), 32'h0);
      chk("rst_running", 32'(running), 32'h0);
      chk("rst_retired", 32'(retired_cnt), 32'h0);
      chk("rst_addr", 32'(ProgLoad_Addr), 32'h0);
      bus.load_valid = 1'b1;
      #1;
      chk("rst_State_valid", 32'(State), 32'h0);
      bus.load_valid = 1'b0;
      rst = 1'b0;

      // Four-word image terminated by load_last
      load_word(12'h801, 1'b0, 8'd0);
      load_word(12'h902, 1'b0, 8'd1);
      load_word(12'h203, 1'b0, 8'd2);
      load_word(12'h40A, 1'b1, 8'd3);
      bus.load_valid = 1'b0; bus.load_last = 1'b0;
      chk("ld4_State", 32'(State), 32'h1);
      chk("ld4_core_rst", 32'(core_rst), 32'h1);
      chk("ld4_load_done", 32'(load_done), 32'h1);
      chk("ld4_load_ready", 32'(bus.load_ready), 32'h0);
      chk("ld4_addr", 32'(ProgLoad_Addr), 32'h4);
      cyc();
      chk("ld4_core_rst_pulse", 32'(core_rst), 32'h0);
      chk("ld4_running", 32'(running), 32'h0);

      // Continuous run for three instructions
      run_en = 1'b1;
      ex_q.push_back(16'd0); ex_q.push_back(16'd1); ex_q.push_back(16'd2);
      for (int k = 1; k <= 9; k++) begin
         cyc();
         chk("run_State", 32'(State), 32'(seq[(k - 1) % 3]));
         chk("run_running", 32'(running), 32'h1);
         if (k == 9) run_en = 1'b0;
      end
      cyc();
      chk("run_end_running", 32'(running), 32'h0);
      chk("run_end_retired", 32'(retired_cnt), 32'd3);
      chk("run_end_State", 32'(State), 32'h1);

      // Single step pulse
      step_req = 1'b1;
      ex_q.push_back(16'd3);
      cyc();
      step_req = 1'b0;
      chk("step_F", 32'(State), 32'h1);
      cyc(); chk("step_D", 32'(State), 32'h2);
      cyc(); chk("step_E", 32'(State), 32'h3);
      cyc();
      chk("step_ready", 32'(running), 32'h0);
      chk("step_retired", 32'(retired_cnt), 32'd4);
      cyc();
      chk("step_stays", 32'(running), 32'h0);

      // step_req held for five cycles
      step_req = 1'b1;
      ex_q.push_back(16'd4);
      cyc(); chk("hold_F", 32'(running), 32'h1);
      cyc();
      cyc(); chk("hold_E", 32'(State), 32'h3);
      cyc(); chk("hold_ready1", 32'(running), 32'h0);
      cyc(); chk("hold_ready2", 32'(running), 32'h0);
      step_req = 1'b0;
      cyc();
      chk("hold_ready3", 32'(running), 32'h0);
      chk("hold_retired", 32'(retired_cnt), 32'd5);

      // run_en with step_req, then halt pulse in DECODE of 2nd instruction
      run_en = 1'b1; step_req = 1'b1;
      ex_q.push_back(16'd5); ex_q.push_back(16'd6);
      cyc(); step_req = 1'b0;
      chk("halt_F1", 32'(State), 32'h1);
      cyc();
      cyc(); chk("halt_E1", 32'(State), 32'h3);
      cyc();
      chk("halt_F2_running", 32'(running), 32'h1);
      chk("halt_F2_State", 32'(State), 32'h1);
      cyc(); chk("halt_D2", 32'(State), 32'h2);
      halt_req = 1'b1;
      cyc(); halt_req = 1'b0;
      chk("halt_E2", 32'(State), 32'h3);
      cyc();
      chk("halt_ready", 32'(running), 32'h0);
      chk("halt_retired", 32'(retired_cnt), 32'd7);
      run_en = 1'b0;
      cyc();
      chk("halt_stays", 32'(running), 32'h0);

      // Reload, then 256 words without load_last
      reload_req = 1'b1;
      cyc();
      reload_req = 1'b0;
      chk("rl_load_ready", 32'(bus.load_ready), 32'h1);
      chk("rl_addr", 32'(ProgLoad_Addr), 32'h0);
      chk("rl_load_done", 32'(load_done), 32'h0);
      for (int i = 0; i < 256; i++) load_word(12'(i) ^ 12'h5A5, 1'b0, 8'(i));
      bus.load_data = 12'hFFF;
      chk("full_load_ready", 32'(bus.load_ready), 32'h0);
      chk("full_load_done", 32'(load_done), 32'h1);
      chk("full_core_rst", 32'(core_rst), 32'h1);
      chk("full_State", 32'(State), 32'h1);
      chk("full_addr_wrap", 32'(ProgLoad_Addr), 32'h0);
      cyc();
      chk("full_257_State", 32'(State), 32'h1);
      chk("full_257_ready", 32'(bus.load_ready), 32'h0);
      bus.load_valid = 1'b0;

      // Asynchronous reset during DECODE
      run_en = 1'b1;
      cyc();
      cyc(); chk("ar_D", 32'(State), 32'h2);
      rst = 1'b1;
      #1;
      chk("ar_State", 32'(State), 32'h1);
      chk("ar_load_done", 32'(load_done), 32'h0);
      chk("ar_retired", 32'(retired_cnt), 32'h0);
      chk("ar_running", 32'(running), 32'h0);
      run_en = 1'b0;
      cyc();
      rst = 1'b0;

      // Load two words, reload, next accepted word goes to address 0
      load_word(12'h111, 1'b0, 8'd0);
      load_word(12'h222, 1'b1, 8'd1);
      bus.load_valid = 1'b0; bus.load_last = 1'b0;
      chk("rl2_load_done", 32'(load_done), 32'h1);
      reload_req = 1'b1;
      cyc();
      reload_req = 1'b0;
      chk("rl2_addr", 32'(ProgLoad_Addr), 32'h0);
      chk("rl2_cleared", 32'(load_done), 32'h0);
      load_word(12'h333, 1'b1, 8'd0);
      bus.load_valid = 1'b0; bus.load_last = 1'b0;
      chk("rl2_done", 32'(load_done), 32'h1);
      chk("rl2_addr_next", 32'(ProgLoad_Addr), 32'h1);
      cyc();

      chk("ld_q_drained", 32'(ld_q.size()), 32'h0);
      chk("ex_q_drained", 32'(ex_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
